// File: rtl/rf_fu_pipe_wrapper_pkg.sv
// Shared types and constants for the SPU execution back-end.
// Buses are MSB-first: an architectural bit i of an N-bit bus maps to RTL bit N-1-i.
package rf_fu_pipe_wrapper_pkg;
   localparam int DATA_W     = 128;
   localparam int NUM_REGS   = 128;
   localparam int ADDR_W     = 7;
   localparam int NUM_STAGES = 7;
   localparam int WORDS      = DATA_W / 32;
   localparam int REC_W      = 143;

   typedef logic [6:0] op_id_t;

   localparam op_id_t OP_NOP     = 7'd0;
   localparam op_id_t OP_A       = 7'd1;
   localparam op_id_t OP_SF      = 7'd2;
   localparam op_id_t OP_AND     = 7'd3;
   localparam op_id_t OP_AI      = 7'd4;
   localparam op_id_t OP_OR      = 7'd5;
   localparam op_id_t OP_XOR     = 7'd6;
   localparam op_id_t OP_IL      = 7'd7;
   localparam op_id_t OP_SELB    = 7'd8;
   localparam op_id_t OP_SHLQBYI = 7'd64;
   localparam op_id_t OP_ROTQBYI = 7'd65;
   localparam op_id_t OP_ROTQBY  = 7'd66;
   localparam op_id_t OP_ILA     = 7'd67;

   // Field order fixes the 143-bit record layout: result occupies the top 128 bits.
   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [ADDR_W-1:0] reg_dst;
      logic [2:0]        unit_id;
      logic [3:0]        latency;
      logic              reg_wr;
   } rec_t;

   function automatic logic [31:0] sext10(input logic [9:0] v);
      return {{22{v[9]}}, v};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   // Byte rotate toward the MSB end; n=0 makes the right shift 128, which yields 0.
   function automatic logic [DATA_W-1:0] rotl_bytes(input logic [DATA_W-1:0] x, input logic [3:0] n);
      logic [7:0] sh;
      sh = {1'b0, n, 3'b000};
      return (x << sh) | (x >> (8'd128 - sh));
   endfunction
endpackage

// File: rtl/rf_fu_pipe_wrapper_pipe_shift7.sv
// Free-running record shift pipeline; stage 1 captures the issued record every edge.
module rf_fu_pipe_wrapper_pipe_shift7
   import rf_fu_pipe_wrapper_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  rec_t                    issue,
   output rec_t [NUM_STAGES:1]     stages
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stages <= '0;
      end else begin
         stages[1] <= issue;
         for (int k = 2; k <= NUM_STAGES; k++) stages[k] <= stages[k-1];
      end
   end
endmodule

// File: rtl/rf_fu_pipe_wrapper_reg_file.sv
// 128 x 128 register file: combinational reads with write bypass, prioritised write ports.
// Write port 0 has the highest priority; the same order decides the bypassed value.
module rf_fu_pipe_wrapper_reg_file
   import rf_fu_pipe_wrapper_pkg::*;
#(
   parameter int RD_PORTS = 6,
   parameter int WR_PORTS = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [RD_PORTS-1:0][ADDR_W-1:0]    rd_addr,
   output logic [RD_PORTS-1:0][DATA_W-1:0]    rd_data,
   input  logic [WR_PORTS-1:0]                wr_en,
   input  logic [WR_PORTS-1:0][ADDR_W-1:0]    wr_addr,
   input  logic [WR_PORTS-1:0][DATA_W-1:0]    wr_data
);
   logic [DATA_W-1:0]   mem [NUM_REGS];
   logic [WR_PORTS-1:0] wr_act;

   assign wr_act = wr_en & {WR_PORTS{rst}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      end else begin
         for (int p = WR_PORTS - 1; p >= 0; p--)
            if (wr_en[p]) mem[wr_addr[p]] <= wr_data[p];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < RD_PORTS; i++) begin
         rd_data[i] = mem[rd_addr[i]];
         for (int p = WR_PORTS - 1; p >= 0; p--)
            if (wr_act[p] && wr_addr[p] == rd_addr[i]) rd_data[i] = wr_data[p];
      end
   end
endmodule

// File: rtl/rf_fu_pipe_wrapper.sv
// Dual-issue SPU back-end: shared RF, even fixed-point FU, odd byte-shift FU,
// and a 7-stage writeback pipe per side.
module rf_fu_pipe_wrapper
   import rf_fu_pipe_wrapper_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       full_instr_even,
   input  logic [31:0]       full_instr_odd,
   input  logic [6:0]        instr_id_even,
   input  logic [6:0]        instr_id_odd,
   input  logic [6:0]        reg_dst_even,
   input  logic [6:0]        reg_dst_odd,
   input  logic [2:0]        unit_id_even,
   input  logic [2:0]        unit_id_odd,
   input  logic [3:0]        latency_even,
   input  logic [3:0]        latency_odd,
   input  logic              reg_wr_even,
   input  logic              reg_wr_odd,
   input  logic [6:0]        imme7_even,
   input  logic [6:0]        imme7_odd,
   input  logic [9:0]        imme10_even,
   input  logic [9:0]        imme10_odd,
   input  logic [15:0]       imme16_even,
   input  logic [15:0]       imme16_odd,
   input  logic [17:0]       imme18_even,
   input  logic [17:0]       imme18_odd,
   input  logic [6:0]        ra_addr_even,
   input  logic [6:0]        rb_addr_even,
   input  logic [6:0]        rc_addr_even,
   input  logic [6:0]        ra_addr_odd,
   input  logic [6:0]        rb_addr_odd,
   input  logic [6:0]        rc_addr_odd,
   input  logic              preload_en,
   input  logic [127:0]      preload_addr,
   input  logic [127:0]      preload_values,
   output logic [REC_W-1:0]  wb_even_out,
   output logic [REC_W-1:0]  wb_odd_out
);
   logic [DATA_W-1:0] ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd;
   logic [DATA_W-1:0] res_even, res_odd;
   logic              ok_even, ok_odd;
   rec_t              issue_even, issue_odd;
   rec_t [NUM_STAGES:1] stages_even, stages_odd;

   rec_t packed_1stage_even, packed_2stage_even, packed_3stage_even, packed_4stage_even;
   rec_t packed_5stage_even, packed_6stage_even, packed_7stage_even;
   rec_t packed_1stage_odd, packed_2stage_odd, packed_3stage_odd, packed_4stage_odd;
   rec_t packed_5stage_odd, packed_6stage_odd, packed_7stage_odd;

   logic [5:0][ADDR_W-1:0] rd_addr;
   logic [5:0][DATA_W-1:0] rd_data;
   logic [2:0]             wr_en;
   logic [2:0][ADDR_W-1:0] wr_addr;
   logic [2:0][DATA_W-1:0] wr_data;
   logic                   unused;

   assign rd_addr = {rc_addr_odd, rb_addr_odd, ra_addr_odd, rc_addr_even, rb_addr_even, ra_addr_even};
   assign {rc_odd, rb_odd, ra_odd, rc_even, rb_even, ra_even} = rd_data;

   // Port order is write priority: preload, then odd writeback, then even writeback.
   assign wr_en   = {packed_7stage_even.reg_wr, packed_7stage_odd.reg_wr, preload_en};
   assign wr_addr = {packed_7stage_even.reg_dst, packed_7stage_odd.reg_dst, preload_addr[ADDR_W-1:0]};
   assign wr_data = {packed_7stage_even.result, packed_7stage_odd.result, preload_values};

   rf_fu_pipe_wrapper_reg_file u_rf (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   always_comb begin
      res_even = '0;
      ok_even  = 1'b1;
      case (instr_id_even)
         OP_A:    for (int w = 0; w < WORDS; w++) res_even[32*w +: 32] = ra_even[32*w +: 32] + rb_even[32*w +: 32];
         OP_SF:   for (int w = 0; w < WORDS; w++) res_even[32*w +: 32] = rb_even[32*w +: 32] - ra_even[32*w +: 32];
         OP_AND:  res_even = ra_even & rb_even;
         OP_AI:   for (int w = 0; w < WORDS; w++) res_even[32*w +: 32] = ra_even[32*w +: 32] + sext10(imme10_even);
         OP_OR:   res_even = ra_even | rb_even;
         OP_XOR:  res_even = ra_even ^ rb_even;
         OP_IL:   res_even = {WORDS{sext16(imme16_even)}};
         OP_SELB: res_even = (rc_even & rb_even) | (~rc_even & ra_even);
         OP_NOP:  ok_even = 1'b0;
         default: ok_even = 1'b0;
      endcase
   end

   // Shift count is imme7 low 5 bits; any count of 16 or more empties the quadword.
   always_comb begin
      res_odd = '0;
      ok_odd  = 1'b1;
      case (instr_id_odd)
         OP_SHLQBYI: res_odd = imme7_odd[4] ? '0 : ra_odd << {imme7_odd[3:0], 3'b000};
         OP_ROTQBYI: res_odd = rotl_bytes(ra_odd, imme7_odd[3:0]);
         OP_ROTQBY:  res_odd = rotl_bytes(ra_odd, rb_odd[99:96]);
         OP_ILA:     res_odd = {WORDS{{14'b0, imme18_odd}}};
         OP_NOP:     ok_odd = 1'b0;
         default:    ok_odd = 1'b0;
      endcase
   end

   assign issue_even = '{result: res_even, reg_dst: reg_dst_even, unit_id: unit_id_even,
                         latency: latency_even, reg_wr: reg_wr_even & ok_even};
   assign issue_odd  = '{result: res_odd, reg_dst: reg_dst_odd, unit_id: unit_id_odd,
                         latency: latency_odd, reg_wr: reg_wr_odd & ok_odd};

   rf_fu_pipe_wrapper_pipe_shift7 u_pipe_even (.clk(clk), .rst(rst), .issue(issue_even), .stages(stages_even));
   rf_fu_pipe_wrapper_pipe_shift7 u_pipe_odd  (.clk(clk), .rst(rst), .issue(issue_odd),  .stages(stages_odd));

   assign packed_1stage_even = stages_even[1];
   assign packed_2stage_even = stages_even[2];
   assign packed_3stage_even = stages_even[3];
   assign packed_4stage_even = stages_even[4];
   assign packed_5stage_even = stages_even[5];
   assign packed_6stage_even = stages_even[6];
   assign packed_7stage_even = stages_even[7];
   assign packed_1stage_odd  = stages_odd[1];
   assign packed_2stage_odd  = stages_odd[2];
   assign packed_3stage_odd  = stages_odd[3];
   assign packed_4stage_odd  = stages_odd[4];
   assign packed_5stage_odd  = stages_odd[5];
   assign packed_6stage_odd  = stages_odd[6];
   assign packed_7stage_odd  = stages_odd[7];

   assign wb_even_out = packed_7stage_even;
   assign wb_odd_out  = packed_7stage_odd;

   // Debug-only and don't-care input bits.
   assign unused = ^{full_instr_even, full_instr_odd, imme7_even, imme18_even, imme10_odd,
                     imme16_odd, imme7_odd[6:5], rb_odd[127:100], rb_odd[95:0], rc_odd,
                     preload_addr[127:ADDR_W], packed_2stage_even, packed_3stage_even,
                     packed_4stage_even, packed_5stage_even, packed_6stage_even,
                     packed_2stage_odd, packed_3stage_odd, packed_4stage_odd,
                     packed_5stage_odd, packed_6stage_odd};
endmodule

// File: tb/tb_rf_fu_pipe_wrapper.sv
// Randomised bench for rf_fu_pipe_wrapper against a quadword/byte-level reference model.
module tb_rf_fu_pipe_wrapper;
   logic clk = 1'b0;
   logic rst;
   logic [31:0]  full_instr_even, full_instr_odd;
   logic [6:0]   instr_id_even, instr_id_odd, reg_dst_even, reg_dst_odd;
   logic [2:0]   unit_id_even, unit_id_odd;
   logic [3:0]   latency_even, latency_odd;
   logic         reg_wr_even, reg_wr_odd;
   logic [6:0]   imme7_even, imme7_odd;
   logic [9:0]   imme10_even, imme10_odd;
   logic [15:0]  imme16_even, imme16_odd;
   logic [17:0]  imme18_even, imme18_odd;
   logic [6:0]   ra_addr_even, rb_addr_even, rc_addr_even, ra_addr_odd, rb_addr_odd, rc_addr_odd;
   logic         preload_en;
   logic [127:0] preload_addr, preload_values;
   logic [142:0] wb_even_out, wb_odd_out;

   logic [127:0] rf_m [128];
   logic [142:0] st_e [1:7];
   logic [142:0] st_o [1:7];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rf_fu_pipe_wrapper dut (
      .clk(clk), .rst(rst),
      .full_instr_even(full_instr_even), .full_instr_odd(full_instr_odd),
      .instr_id_even(instr_id_even), .instr_id_odd(instr_id_odd),
      .reg_dst_even(reg_dst_even), .reg_dst_odd(reg_dst_odd),
      .unit_id_even(unit_id_even), .unit_id_odd(unit_id_odd),
      .latency_even(latency_even), .latency_odd(latency_odd),
      .reg_wr_even(reg_wr_even), .reg_wr_odd(reg_wr_odd),
      .imme7_even(imme7_even), .imme7_odd(imme7_odd),
      .imme10_even(imme10_even), .imme10_odd(imme10_odd),
      .imme16_even(imme16_even), .imme16_odd(imme16_odd),
      .imme18_even(imme18_even), .imme18_odd(imme18_odd),
      .ra_addr_even(ra_addr_even), .rb_addr_even(rb_addr_even), .rc_addr_even(rc_addr_even),
      .ra_addr_odd(ra_addr_odd), .rb_addr_odd(rb_addr_odd), .rc_addr_odd(rc_addr_odd),
      .preload_en(preload_en), .preload_addr(preload_addr), .preload_values(preload_values),
      .wb_even_out(wb_even_out), .wb_odd_out(wb_odd_out)
   );

   task automatic chk(input string tag, input logic [142:0] got, input logic [142:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] ref_even(input int id, input logic [127:0] a, b, c,
                                             input logic [9:0] i10, input logic [15:0] i16);
      logic [127:0] r;
      r = '0;
      for (int w = 0; w < 4; w++) begin
         logic [31:0] x, y, z, o;
         x = a[32*w +: 32]; y = b[32*w +: 32]; z = c[32*w +: 32];
         case (id)
            1: o = x + y;
            2: o = y - x;
            3: o = x & y;
            4: o = x + {{22{i10[9]}}, i10};
            5: o = x | y;
            6: o = x ^ y;
            7: o = {{16{i16[15]}}, i16};
            8: o = (z & y) | (~z & x);
            default: o = '0;
         endcase
         r[32*w +: 32] = o;
      end
      return r;
   endfunction

   // Byte 0 is the most significant byte of the quadword.
   function automatic logic [127:0] ref_odd(input int id, input logic [127:0] a, b,
                                            input logic [6:0] i7, input logic [17:0] i18);
      logic [7:0] by [16];
      logic [7:0] ob [16];
      logic [127:0] r;
      int n;
      r = '0;
      for (int i = 0; i < 16; i++) by[i] = a[127-8*i -: 8];
      case (id)
         64: begin
            n = int'(i7[4:0]);
            for (int i = 0; i < 16; i++) ob[i] = (i + n < 16) ? by[(i + n) % 16] : 8'h00;
         end
         65, 66: begin
            n = (id == 65) ? int'(i7[3:0]) : int'(b[99:96]);
            for (int i = 0; i < 16; i++) ob[i] = by[(i + n) % 16];
         end
         67: return {4{14'b0, i18}};
         default: return '0;
      endcase
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = ob[i];
      return r;
   endfunction

   // One clock: check outputs, advance the model across the coming edge, pass the edge.
   task automatic cyc();
      logic [127:0] re, ro;
      logic         ve, vo;
      @(negedge clk);
      chk("wb_even", wb_even_out, rst ? st_e[7] : '0);
      chk("wb_odd",  wb_odd_out,  rst ? st_o[7] : '0);
      chk("s1_even", dut.packed_1stage_even, rst ? st_e[1] : '0);
      chk("s1_odd",  dut.packed_1stage_odd,  rst ? st_o[1] : '0);
      if (!rst) begin
         for (int r = 0; r < 128; r++) rf_m[r] = '0;
         for (int k = 1; k <= 7; k++) begin st_e[k] = '0; st_o[k] = '0; end
      end else begin
         if (st_e[7][0]) rf_m[st_e[7][14:8]] = st_e[7][142:15];
         if (st_o[7][0]) rf_m[st_o[7][14:8]] = st_o[7][142:15];
         if (preload_en) rf_m[preload_addr[6:0]] = preload_values;
         re = ref_even(int'(instr_id_even), rf_m[ra_addr_even], rf_m[rb_addr_even],
                       rf_m[rc_addr_even], imme10_even, imme16_even);
         ro = ref_odd(int'(instr_id_odd), rf_m[ra_addr_odd], rf_m[rb_addr_odd], imme7_odd, imme18_odd);
         ve = (instr_id_even >= 1 && instr_id_even <= 8);
         vo = (instr_id_odd >= 64 && instr_id_odd <= 67);
         for (int k = 7; k >= 2; k--) begin st_e[k] = st_e[k-1]; st_o[k] = st_o[k-1]; end
         st_e[1] = {re, reg_dst_even, unit_id_even, latency_even, reg_wr_even & ve};
         st_o[1] = {ro, reg_dst_odd, unit_id_odd, latency_odd, reg_wr_odd & vo};
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      {full_instr_even, full_instr_odd, instr_id_even, instr_id_odd, reg_dst_even, reg_dst_odd} = '0;
      {unit_id_even, unit_id_odd, latency_even, latency_odd, reg_wr_even, reg_wr_odd} = '0;
      {imme7_even, imme7_odd, imme10_even, imme10_odd, imme16_even, imme16_odd, imme18_even, imme18_odd} = '0;
      {ra_addr_even, rb_addr_even, rc_addr_even, ra_addr_odd, rb_addr_odd, rc_addr_odd} = '0;
      {preload_en, preload_addr, preload_values} = '0;
   endtask

   task automatic preload(input logic [6:0] a, input logic [127:0] v);
      set_idle();
      preload_en = 1'b1;
      preload_addr = {121'h0, a};
      preload_values = v;
   endtask

   task automatic issue_even(input logic [6:0] id, ra, rb, dst, input logic wr, input logic [9:0] i10);
      instr_id_even = id; ra_addr_even = ra; rb_addr_even = rb; reg_dst_even = dst;
      reg_wr_even = wr; imme10_even = i10; unit_id_even = 3'd2; latency_even = 4'd2;
   endtask

   // Issue the staged inputs, then let them drain to stage 7.
   task automatic fly();
      cyc();
      set_idle();
      repeat (6) cyc();
   endtask

   function automatic logic [127:0] rnd128();
      logic [127:0] v;
      v = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) v[31:0] = 32'hFFFF_FFFF;
      return v;
   endfunction

   task automatic rnd();
      int pe [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 100, 64};
      int po [8]  = '{0, 64, 65, 66, 67, 3, 127, 68};
      full_instr_even = $urandom; full_instr_odd = $urandom;
      instr_id_even = 7'(pe[$urandom_range(0, 10)]);
      instr_id_odd  = 7'(po[$urandom_range(0, 7)]);
      reg_dst_even = 7'($urandom_range(0, 15)); reg_dst_odd = 7'($urandom_range(0, 15));
      unit_id_even = 3'($urandom); unit_id_odd = 3'($urandom);
      latency_even = 4'($urandom); latency_odd = 4'($urandom);
      reg_wr_even = 1'($urandom); reg_wr_odd = 1'($urandom);
      imme7_even = 7'($urandom); imme7_odd = 7'($urandom);
      imme10_even = 10'($urandom); imme10_odd = 10'($urandom);
      imme16_even = 16'($urandom); imme16_odd = 16'($urandom);
      imme18_even = 18'($urandom); imme18_odd = 18'($urandom);
      ra_addr_even = 7'($urandom_range(0, 15)); rb_addr_even = 7'($urandom_range(0, 15));
      rc_addr_even = 7'($urandom_range(0, 15)); ra_addr_odd = 7'($urandom_range(0, 15));
      rb_addr_odd = 7'($urandom_range(0, 15)); rc_addr_odd = 7'($urandom_range(0, 15));
      preload_en = ($urandom_range(0, 5) == 0);
      preload_addr = rnd128();
      preload_addr[6:0] = 7'($urandom_range(0, 15));
      preload_values = rnd128();
   endtask

   initial begin
      logic [127:0] seq, rot;
      seq = 128'h000102030405060708090A0B0C0D0E0F;
      rot = 128'h0102030405060708090A0B0C0D0E0F00;
      rst = 1'b1;
      set_idle();
      #1 rst = 1'b0;
      #1;
      chk("rst_wb_even", wb_even_out, '0);
      chk("rst_wb_odd",  wb_odd_out,  '0);
      preload(7'd7, {4{32'h1234_5678}});
      repeat (2) cyc();
      rst = 1'b1;

      preload(7'd1, {4{32'd1}}); cyc();
      preload(7'd2, {4{32'd2}}); cyc();
      preload(7'd3, {4{32'd3}}); cyc();
      set_idle();

      issue_even(7'd4, 7'd2, 7'd0, 7'd1, 1'b1, 10'd3);
      cyc();
      chk("ai_s1", dut.packed_1stage_even[142:15], {4{32'd5}});
      set_idle();
      repeat (6) cyc();
      chk("ai_wb", wb_even_out[142:15], {4{32'd5}});
      chk("ai_wr", wb_even_out[0], 1'b1);
      issue_even(7'd5, 7'd1, 7'd1, 7'd9, 1'b0, 10'd0);
      fly();
      chk("rdw_r1", wb_even_out[142:15], {4{32'd5}});

      preload(7'd2, seq); cyc(); set_idle();
      instr_id_odd = 7'd65; ra_addr_odd = 7'd2; imme7_odd = 7'd1; reg_dst_odd = 7'd4; reg_wr_odd = 1'b1;
      fly();
      chk("rot_wb", wb_odd_out[142:15], rot);
      chk("rot_even_idle", wb_even_out, '0);

      issue_even(7'd7, 7'd0, 7'd0, 7'd5, 1'b1, 10'd0); imme16_even = 16'h1111;
      instr_id_odd = 7'd67; imme18_odd = 18'h22222; reg_dst_odd = 7'd5; reg_wr_odd = 1'b1;
      fly();
      cyc();
      issue_even(7'd5, 7'd5, 7'd5, 7'd10, 1'b0, 10'd0);
      fly();
      chk("clash_odd", wb_even_out[142:15], {4{32'h0002_2222}});

      issue_even(7'd7, 7'd0, 7'd0, 7'd5, 1'b1, 10'd0); imme16_even = 16'h1111;
      instr_id_odd = 7'd67; imme18_odd = 18'h22222; reg_dst_odd = 7'd5; reg_wr_odd = 1'b1;
      fly();
      preload(7'd5, {4{32'hCAFE_F00D}});
      cyc();
      set_idle();
      issue_even(7'd5, 7'd5, 7'd5, 7'd10, 1'b0, 10'd0);
      fly();
      chk("clash_pre", wb_even_out[142:15], {4{32'hCAFE_F00D}});

      issue_even(7'd4, 7'd0, 7'd0, 7'd11, 1'b1, 10'h3FF);
      fly();
      chk("ai_neg1", wb_even_out[142:15], {4{32'hFFFF_FFFF}});
      preload(7'd6, {4{32'hFFFF_FFFF}}); cyc(); set_idle();
      issue_even(7'd4, 7'd6, 7'd0, 7'd12, 1'b1, 10'd1);
      fly();
      chk("wrap0", wb_even_out[142:15], '0);

      issue_even(7'd100, 7'd2, 7'd2, 7'd1, 1'b1, 10'd0);
      fly();
      chk("unk_wr", wb_even_out[0], 1'b0);
      chk("unk_res", wb_even_out[142:15], '0);
      cyc();
      issue_even(7'd5, 7'd1, 7'd1, 7'd13, 1'b0, 10'd0);
      fly();
      chk("unk_keep", wb_even_out[142:15], {4{32'd5}});

      repeat (400) begin
         rnd();
         cyc();
      end

      #2 rst = 1'b0;
      #1;
      chk("arst_wb_even", wb_even_out, '0);
      chk("arst_wb_odd",  wb_odd_out,  '0);
      chk("arst_s7_even", dut.packed_7stage_even, '0);
      chk("arst_s7_odd",  dut.packed_7stage_odd,  '0);
      chk("arst_rd", dut.ra_even, '0);
      preload(7'd3, {4{32'h5555_AAAA}});
      repeat (2) cyc();
      rst = 1'b1;
      set_idle();
      repeat (150) begin
         rnd();
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rf_fu_pipe_wrapper.md
Name: rf_fu_pipe_wrapper

Overview:
Execution back-end of the dual-issue SPU core.
- Holds a 128 x 128-bit register file (RF) with six read ports.
- Feeds an even pipe (simple fixed-point unit) and an odd pipe (byte shift/rotate unit).
- Each pipe carries its result through a 7-stage packed shift pipeline and writes it back to the RF from stage 7.
- Sits directly after decode/issue. A preload port initialises the RF for verification.

Parameters:
DATA_W, 128, register and result width
NUM_REGS, 128, RF depth (7-bit addresses)
NUM_STAGES, 7, packed pipeline depth per pipe

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
full_instr_even / full_instr_odd  in  32  raw instruction word (carried for debug only)
instr_id_even / instr_id_odd  in  7  decoded operation id
reg_dst_even / reg_dst_odd  in  7  destination register RT
unit_id_even / unit_id_odd  in  3  executing unit tag
latency_even / latency_odd  in  4  unit latency tag
reg_wr_even / reg_wr_odd  in  1  result writes RF
imme7_*, imme10_*, imme16_*, imme18_* (even/odd)  in  7/10/16/18  immediates
ra_addr_even, rb_addr_even, rc_addr_even, ra_addr_odd, rb_addr_odd, rc_addr_odd  in  7  RF read addresses
preload_en  in  1  RF preload strobe
preload_addr  in  128  preload address; only bits [121:127] are used
preload_values  in  128  preload data
wb_even_out / wb_odd_out  out  143  stage-7 packed record of each pipe

Behaviour:
- Bit numbering: all buses are [0:N-1] with bit 0 as MSB. Word w of a 128-bit value occupies bits [32w:32w+31].
- Packed record (143 bits), fields in order: result[128], reg_dst[7], unit_id[3], latency[4], reg_wr[1].
- Internal stage registers are named packed_1stage_even … packed_7stage_even and packed_1stage_odd … packed_7stage_odd.
- Reset (rst=0, asynchronous): all RF entries and all 14 stage registers clear to 0, so wb_*_out = 0. Preload is ignored while in reset.
- RF reads are combinational.
- Read-during-write: a read of an address being written this cycle returns the new data, either from a stage-7 writeback or from a preload.
- Issue: the FU computes combinationally from the current inputs and RF reads. Stage 1 captures {result, reg_dst, unit_id, latency, reg_wr_eff} on the next edge.
- Shift: every edge, stage k+1 <= stage k for k = 1..6, unconditionally; there is no stall.
- Writeback: on the edge where stage 7 holds a record with reg_wr=1, RF[reg_dst] <= result. Inputs sampled at edge k are written at edge k+7.
- The latency field is carried unchanged. It does not alter timing and is reserved for forwarding logic.
- Write priority per edge: preload first, then odd writeback, then even writeback. On an address clash the highest-priority writer wins.
- Even pipe instr_id map (word-wise 32-bit, wrap-around arithmetic):
  - 0 nop (result 0, reg_wr_eff=0)
  - 1 a: ra+rb
  - 2 sf: rb−ra
  - 3 and: ra&rb
  - 4 ai: ra+sext(imme10)
  - 5 or: ra|rb
  - 6 xor: ra^rb
  - 7 il: sext(imme16) in every word
  - 8 selb: (rc&rb)|(~rc&ra)
- Odd pipe instr_id map:
  - 0 nop
  - 64 shlqbyi: ra shifted left by imme7[2:6] bytes, zero fill; counts ≥16 give 0
  - 65 rotqbyi: ra rotated left by imme7[3:6] bytes
  - 66 rotqby: ra rotated left by rb[28:31] bytes
  - 67 ila: zero-extended imme18 in every word
- Any unlisted id behaves as nop.
- reg_wr_eff = reg_wr && (id is a valid non-nop id).

Decomposition:
- Shared package: DATA_W, NUM_REGS, NUM_STAGES, the packed-record field offsets/width (143), and the instr_id constants.
- Natural sub-modules: reg_file_128x128 (6 read ports, 2 writeback ports plus preload, async clear), and one pipe_shift7 instantiated once per pipe.
- FU datapaths stay inline.

Test Plan:
- Reset: drive rst=0 mid-run → all packed stages, wb_*_out and RF reads go to 0 immediately, without waiting for a clock edge.
- Preload + ai: preload r1=1, r2=2, r3=3 (all words), release preload; issue even id 4, ra=2, imme10=3, dst=1, reg_wr=1.
  - packed_1stage_even result = 00000005×4 one edge later; it reaches stage 7 after six more edges.
  - r1 reads 00000005×4 after edge k+7.
- Odd rotqbyi: r2 = 0x00..0F, imme7=1 → result rotated left by 1 byte; written to dst after 7 edges; even pipe unaffected.
- Writeback clash: even and odd both write r5 on the same edge → r5 takes the odd value. Add a simultaneous preload to r5 → r5 takes the preload value.
- Read-during-write: read r1 via ra_addr_even in the writeback cycle → the new value is returned combinationally.
- Edge cases:
  - ai with imme10=0x3FF (−1) on word 0 → FFFFFFFF.
  - Word 0xFFFFFFFF+1 → 0.
  - Unknown id 100 with reg_wr=1 → no RF write.
